// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// Multi-stage CIC decimator for the DFE chain. Consumes samples from the IIR
// notch stage, decimates by R = 2^k (k = clamped dec_sel), normalises the CIC
// gain R^N back to unity (less EXTRA_GAIN bits), rounds half-up and saturates
// to signed Q1.(DATA_FRAC) full scale.
//
// Ports
//   clk        in   1           clock
//   rst_n      in   1           asynchronous reset, active-low
//   valid_in   in   1           cic_in carries a sample this cycle
//   bypass     in   1           1: pass cic_in straight through, no decimation
//   dec_sel    in   3           k = log2(R); values above MAX_DEC_LOG2 clamp
//   cic_in     in   DATA_WIDTH  signed input sample
//   cic_out    out  DATA_WIDTH  signed decimated output sample
//   overflow   out  1           positive saturation applied to cic_out
//   underflow  out  1           negative saturation applied to cic_out
//   valid_out  out  1           single-cycle strobe: cic_out is new
//
// Pipeline
//   p0 : integrators + sample counter; vld_p0 marks the sample closing a group
//   p1 : comb cascade (combinational) + normalise/round/saturate
//   p2 : output registers (cic_out / flags / valid_out)
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int N_STAGES     = 5,
  parameter int MAX_DEC_LOG2 = 4,
  parameter int EXTRA_GAIN   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         bypass,
  input  logic [2:0]                   dec_sel,
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         valid_out
);

  // Word growth of an N-stage CIC at R_max is N*log2(R_max) bits; with
  // two's-complement wrap this width makes the comb output exact.
  localparam int ACC_WIDTH = DATA_WIDTH + N_STAGES * MAX_DEC_LOG2;
  localparam int CNT_W     = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

  localparam logic [2:0] K_MAX = 3'(MAX_DEC_LOG2);

  // Saturation bounds are +/- full scale of the Q1.DATA_FRAC output format.
  localparam longint SAT_MAX_L = (longint'(1) <<< DATA_FRAC) - 1;
  localparam longint SAT_MIN_L = -(longint'(1) <<< DATA_FRAC);
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(SAT_MAX_L);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(SAT_MIN_L);

  typedef struct packed {
    logic                         ovf;
    logic                         unf;
    logic signed [DATA_WIDTH-1:0] data;
  } sat_t;

  // Normalisation shift: removes the R^N = 2^(N*k) CIC gain, keeping
  // EXTRA_GAIN bits of it; never shifts left.
  function automatic int norm_shift(input logic [2:0] k);
    int s;
    s = N_STAGES * int'(k) - EXTRA_GAIN;
    return (s > 0) ? s : 0;
  endfunction

  // Round half-up then arithmetic shift. One guard bit keeps the rounding
  // add from wrapping at the positive end of the accumulator range.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] v,
    input int                          s
  );
    logic signed [ACC_WIDTH:0] wide;
    logic signed [ACC_WIDTH:0] half;
    wide = {v[ACC_WIDTH-1], v};
    half = '0;
    if (s > 0) half = (ACC_WIDTH+1)'(longint'(1) <<< (s - 1));
    return (wide + half) >>> s;
  endfunction

  function automatic sat_t saturate(input logic signed [ACC_WIDTH:0] v);
    sat_t r;
    r.ovf  = 1'b0;
    r.unf  = 1'b0;
    r.data = v[DATA_WIDTH-1:0];
    if (v > SAT_HI) begin
      r.ovf  = 1'b1;
      r.data = DATA_WIDTH'(SAT_MAX_L);
    end else if (v < SAT_LO) begin
      r.unf  = 1'b1;
      r.data = DATA_WIDTH'(SAT_MIN_L);
    end
    return r;
  endfunction

  logic [2:0]                  k_sel;
  logic [2:0]                  dec_sel_q;
  logic                        sel_change;
  logic                        clear;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_last;
  logic                        vld_p0;
  logic                        vld_p1;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] integ [N_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_out_p1;
  logic signed [ACC_WIDTH:0]   rnd_p1;
  sat_t                        sat_p1;

  assign k_sel = (dec_sel > K_MAX) ? K_MAX : dec_sel;

  // A change of decimation factor invalidates everything in flight: the
  // integrators and comb delays hold history accumulated for the old R.
  // Bypass keeps the same state cleared so leaving it starts fresh.
  assign sel_change = (k_sel != dec_sel_q);
  assign clear      = bypass | sel_change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_sel_q <= '0;
    end else begin
      dec_sel_q <= k_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: integrators and decimation counter (advance on valid_in only)
  // ---------------------------------------------------------------------------
  assign in_ext   = {{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
  assign cnt_last = CNT_W'((32'd1 << dec_sel_q) - 32'd1);
  assign vld_p0   = valid_in & (cnt == cnt_last) & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (valid_in) begin
      cnt <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
    end
  end

  // Each integrator adds the previous stage's old value, giving the
  // N_STAGES-1 sample pipeline delay through the cascade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STAGES; i++) integ[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_STAGES; i++) integ[i] <= '0;
    end else if (valid_in) begin
      integ[0] <= integ[0] + in_ext;
      for (int i = 1; i < N_STAGES; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: comb cascade at the decimated rate, then normalise and saturate
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_STAGES; i++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] c_in;
    logic signed [ACC_WIDTH-1:0] c;
    logic signed [ACC_WIDTH-1:0] d;

    if (i == 0) begin : g_head
      assign c_in = integ[N_STAGES-1];
    end else begin : g_tail
      assign c_in = g_comb[i-1].c;
    end

    assign c = c_in - d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d <= '0;
      end else if (clear) begin
        d <= '0;
      end else if (vld_p1) begin
        d <= c_in;
      end
    end
  end

  assign comb_out_p1 = g_comb[N_STAGES-1].c;
  assign rnd_p1      = round_shift(comb_out_p1, norm_shift(dec_sel_q));
  assign sat_p1      = saturate(rnd_p1);

  // ---------------------------------------------------------------------------
  // Stage p2: output registers. Bypass has priority over a pending decimated
  // sample; a dec_sel change in the comb cycle drops that sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cic_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      valid_out <= 1'b0;
    end else if (bypass) begin
      cic_out   <= cic_in;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      valid_out <= valid_in;
    end else if (vld_p1 && !sel_change) begin
      cic_out   <= sat_p1.data;
      overflow  <= sat_p1.ovf;
      underflow <= sat_p1.unf;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Two decimators (EXTRA_GAIN = 0 and 1) share one randomised stimulus stream.
// The reference model keeps the sample history since the last restart and
// evaluates each decimated output as a direct convolution with the CIC impulse
// response (1 + z^-1 + ... + z^-(R-1))^N delayed by N-1 samples, then applies
// the output normalisation. Expected outputs are queued with the cycle they
// must appear in; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_cic_decimator;

  localparam int DW   = 16;
  localparam int N    = 5;
  localparam int MAXK = 4;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic                 bypass = 1'b0;
  logic [2:0]           dec_sel = 3'd0;
  logic signed [DW-1:0] cic_in = '0;

  logic signed [DW-1:0] out0, out1;
  logic                 ovf0, unf0, vo0;
  logic                 ovf1, unf1, vo1;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint hist[$];
  longint h[$];
  int     mk = 0;
  int     sel_q_m = 0;

  cic_decimator #(
    .DATA_WIDTH(16), .DATA_FRAC(15), .N_STAGES(N), .MAX_DEC_LOG2(MAXK), .EXTRA_GAIN(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .bypass(bypass), .dec_sel(dec_sel),
    .cic_in(cic_in), .cic_out(out0), .overflow(ovf0), .underflow(unf0), .valid_out(vo0)
  );

  cic_decimator #(
    .DATA_WIDTH(16), .DATA_FRAC(15), .N_STAGES(N), .MAX_DEC_LOG2(MAXK), .EXTRA_GAIN(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .bypass(bypass), .dec_sel(dec_sel),
    .cic_in(cic_in), .cic_out(out1), .overflow(ovf1), .underflow(unf1), .valid_out(vo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic void build_h(input int k);
    longint t[$];
    longint acc;
    int     r;
    r = 1 << k;
    h.delete();
    h.push_back(64'sd1);
    for (int st = 0; st < N; st++) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        acc = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
        t.push_back(acc);
      end
      h = t;
    end
  endfunction

  function automatic exp_t make_exp(input longint y, input int k, input int eg, input int c);
    exp_t   e;
    int     s;
    longint v;
    s = N * k - eg;
    if (s < 0) s = 0;
    v = y;
    if (s > 0) v = (v + (longint'(1) << (s - 1))) >>> s;
    e.cyc = c;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (v > 32767) begin
      e.data = 16'h7FFF; e.ovf = 1'b1;
    end else if (v < -32768) begin
      e.data = 16'h8000; e.unf = 1'b1;
    end else begin
      e.data = 16'(v);
    end
    return e;
  endfunction

  function automatic void drop_after(input int c);
    while (q0.size() > 0 && q0[q0.size()-1].cyc > c) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1].cyc > c) void'(q1.pop_back());
  endfunction

  function automatic void add_sample(input logic signed [15:0] x, input int c);
    longint y;
    int     n;
    int     idx;
    hist.push_back(longint'(x));
    if (hist.size() % (1 << mk) == 0) begin
      n = hist.size() - 1;
      y = 0;
      for (int j = 0; j < h.size(); j++) begin
        idx = n - (N - 1) - j;
        if (idx >= 0) y += h[j] * hist[idx];
      end
      q0.push_back(make_exp(y, mk, 0, c + 2));
      q1.push_back(make_exp(y, mk, 1, c + 2));
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic expire(input int id);
    exp_t e;
    for (int g = 0; g < 64; g++) begin
      if (id == 0 && q0.size() > 0 && q0[0].cyc < cyc) e = q0.pop_front();
      else if (id == 1 && q1.size() > 0 && q1[0].cyc < cyc) e = q1.pop_front();
      else break;
      n_cmp++;
      n_fail++;
      $display("FAIL dut%0d missing output: got no valid_out by cycle %0d, required data=%h at cycle %0d",
               id, cyc, e.data, e.cyc);
    end
  endtask

  task automatic check_out(input int id, input logic [15:0] d, input logic o, input logic u);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    n_cmp++;
    if (!have) begin
      n_fail++;
      $display("FAIL dut%0d unexpected output: got data=%h at cycle %0d, required no valid_out", id, d, cyc);
    end else if (e.cyc != cyc || e.data !== d || e.ovf !== o || e.unf !== u) begin
      n_fail++;
      $display("FAIL dut%0d output: got cyc=%0d data=%h ovf=%b unf=%b, required cyc=%0d data=%h ovf=%b unf=%b",
               id, cyc, d, o, u, e.cyc, e.data, e.ovf, e.unf);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      expire(0);
      expire(1);
      if (vo0) check_out(0, out0, ovf0, unf0);
      if (vo1) check_out(1, out1, ovf1, unf1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic signed [15:0] x, input logic byp, input logic [2:0] sel);
    int c;
    int kc;
    c        = cyc;
    valid_in = v;
    cic_in   = x;
    bypass   = byp;
    dec_sel  = sel;
    kc = (int'(sel) > MAXK) ? MAXK : int'(sel);
    if (kc != sel_q_m) begin
      drop_after(c);
      hist.delete();
      mk = kc;
      build_h(mk);
    end
    if (byp) begin
      drop_after(c);
      hist.delete();
      if (v) begin
        exp_t e;
        e.cyc = c + 1; e.data = x; e.ovf = 1'b0; e.unf = 1'b0;
        q0.push_back(e);
        q1.push_back(e);
      end
    end else if (kc == sel_q_m && v) begin
      add_sample(x, c);
    end
    sel_q_m = kc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] sel);
    for (int i = 0; i < n; i++) step(1'b0, 16'sd0, 1'b0, sel);
  endtask

  // rnd = 1: random samples, otherwise constant dc; gap_pct: chance of idle cycles
  task automatic run(input int nsamp, input bit rnd, input logic signed [15:0] dc,
                     input int gap_pct, input logic [2:0] sel);
    for (int i = 0; i < nsamp; i++) begin
      for (int g = 0; g < 6; g++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step(1'b0, 16'($urandom), 1'b0, sel);
        else break;
      end
      step(1'b1, rnd ? 16'($urandom) : dc, 1'b0, sel);
    end
  endtask

  task automatic run_bypass(input int n, input logic [2:0] sel);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, sel);
  endtask

  initial begin
    build_h(0);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset dut0", {13'd0, vo0, ovf0, unf0, out0}, 32'd0);
    check_val("reset dut1", {13'd0, vo1, ovf1, unf1, out1}, 32'd0);
    rst_n = 1'b1;

    // R = 1 impulse response, then random data with gaps
    idle(2, 3'd0);
    step(1'b1, 16'sh4000, 1'b0, 3'd0);
    for (int i = 0; i < 11; i++) step(1'b1, 16'sd0, 1'b0, 3'd0);
    run(20, 1'b1, 16'sd0, 30, 3'd0);

    // R = 4: DC settling, then random with gaps
    idle(3, 3'd0);
    step(1'b0, 16'sd0, 1'b0, 3'd2);
    run(40, 1'b0, 16'sh2000, 0, 3'd2);
    run(40, 1'b1, 16'sd0, 40, 3'd2);

    // R = 16 via clamped dec_sel; -1.0 DC, then an equivalent clamped value mid-stream
    idle(3, 3'd2);
    step(1'b0, 16'sd0, 1'b0, 3'd7);
    run(160, 1'b0, -16'sh8000, 0, 3'd7);
    run(160, 1'b0, -16'sh8000, 50, 3'd5);
    run(64, 1'b1, 16'sd0, 30, 3'd4);

    // R = 4 near full scale: the EXTRA_GAIN = 1 instance saturates both ways
    idle(3, 3'd4);
    step(1'b0, 16'sd0, 1'b0, 3'd2);
    run(40, 1'b0, 16'sh6000, 0, 3'd2);
    run(40, 1'b0, -16'sh6000, 20, 3'd2);

    // dec_sel change mid-group, then change in the cycle after a group closes
    idle(3, 3'd2);
    run(2, 1'b1, 16'sd0, 0, 3'd2);
    step(1'b0, 16'sd0, 1'b0, 3'd3);
    run(16, 1'b1, 16'sd0, 0, 3'd3);
    step(1'b0, 16'sd0, 1'b0, 3'd2);
    run(12, 1'b1, 16'sd0, 0, 3'd2);

    // bypass rising right after a group closes, then a fresh restart
    run_bypass(20, 3'd2);
    run(40, 1'b1, 16'sd0, 30, 3'd2);

    // asynchronous reset in the middle of a group
    idle(3, 3'd2);
    step(1'b0, 16'sd0, 1'b0, 3'd3);
    run(20, 1'b1, 16'sd0, 0, 3'd3);
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("async reset dut0", {13'd0, vo0, ovf0, unf0, out0}, 32'd0);
    check_val("async reset dut1", {13'd0, vo1, ovf1, unf1, out1}, 32'd0);
    q0.delete();
    q1.delete();
    hist.delete();
    sel_q_m = 0;
    mk = 0;
    build_h(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(40, 1'b1, 16'sd0, 25, 3'd1);

    idle(8, 3'd1);
    check_val("drained dut0", q0.size(), 32'd0);
    check_val("drained dut1", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
